// File: rtl/mul_share_arb.sv
// Round-robin arbiter/sequencer sharing one signed multiplier between NREQ requesters.
// A winner's operands are latched and held for CALC_CYCLES cycles. The registered
// product is then returned with the winner's ID on a single response channel.
// Optional build macro MUL_SHARE_ARB_STATS_EN adds stat_ops / stat_stall counters.
module mul_share_arb #(
    parameter int unsigned INPUTSIZE   = 4,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned IDW         = 2,
    parameter int unsigned CALC_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*INPUTSIZE-1:0] req_a,
    input  logic [NREQ*INPUTSIZE-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [2*INPUTSIZE-1:0]    rsp_z,
    output logic                      rsp_zf,
    output logic                      busy
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]               stat_ops,
    output logic [15:0]               stat_stall
`endif
);

    localparam int unsigned    PW       = 2 * INPUTSIZE;
    localparam logic [IDW-1:0] LAST     = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);
    localparam logic [3:0]     CNT_INIT = 4'(CALC_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e                 state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [INPUTSIZE-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [IDW-1:0]         gnt_id_q, gnt_id_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]         rsp_id_q, rsp_id_d;
    logic [PW-1:0]          rsp_z_q, rsp_z_d;
    logic                   rsp_zf_q, rsp_zf_d;

    logic [2*NREQ-1:0]      rot;
    logic [IDW:0]           sum;
    logic                   gnt_found;
    logic [IDW-1:0]         gnt_idx;
    logic [INPUTSIZE-1:0]   sel_a, sel_b;
    logic [NREQ-1:0]        gnt_vec;
    logic signed [PW-1:0]   a_ext, b_ext;
    logic [PW-1:0]          prod;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        rot       = {req_valid, req_valid} >> rr_ptr_q;
        sum       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        // Descending scan so the lowest rotated offset wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_found = 1'b1;
                sum       = {1'b0, rr_ptr_q} + (IDW + 1)'(i);
                if (sum >= NREQ_W) begin
                    sum = sum - NREQ_W;
                end
                gnt_idx = sum[IDW-1:0];
            end
        end
    end

    // Operand mux and one-hot grant vector for the current winner.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        gnt_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a      = req_a[i*INPUTSIZE +: INPUTSIZE];
                sel_b      = req_b[i*INPUTSIZE +: INPUTSIZE];
                gnt_vec[i] = 1'b1;
            end
        end
    end

    // Shared multiplier, fed only from the latched operands; sign-extend so the
    // most-negative operand pair is exact.
    assign a_ext = {{INPUTSIZE{op_a_q[INPUTSIZE-1]}}, op_a_q};
    assign b_ext = {{INPUTSIZE{op_b_q[INPUTSIZE-1]}}, op_b_q};
    assign prod  = a_ext * b_ext;

    // req_ready is held low during reset even though the search is combinational.
    assign req_ready = (state_q == StIdle && !rst && gnt_found) ? gnt_vec : '0;
    assign busy      = (state_q != StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_zf    = rsp_zf_q;

    // Sequencer next-state: grant in IDLE, count down in CALC, hold in RESP.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        gnt_id_d    = gnt_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        rsp_zf_d    = rsp_zf_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    gnt_id_d = gnt_idx;
                    rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == 4'd0) begin
                    rsp_z_d     = prod;
                    rsp_zf_d    = (prod == '0);
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gnt_id_q;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            rsp_zf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_id_q    <= gnt_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            rsp_zf_q    <= rsp_zf_d;
        end
    end

`ifdef MUL_SHARE_ARB_STATS_EN
    // Saturating counters: completed responses and cycles with a request but no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready && stat_ops != 16'hFFFF) begin
                stat_ops <= stat_ops + 16'd1;
            end
            if ((|req_valid) && !(|req_ready) && stat_stall != 16'hFFFF) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: a request-level model predicts each grant
// and product; a separate monitor checks responses as the DUT presents them.
module tb_mul_share_arb;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int C   = 2;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [2*W-1:0] rsp_z;
    logic           rsp_zf, busy;
`ifdef MUL_SHARE_ARB_STATS_EN
    logic [15:0]    stat_ops, stat_stall;
`endif

    mul_share_arb #(.INPUTSIZE(W), .NREQ(N), .IDW(IDW), .CALC_CYCLES(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_zf    (rsp_zf),
        .busy      (busy)
`ifdef MUL_SHARE_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int z;
        int acc;
    } exp_t;
    exp_t sbq[$];

    // Request-level model state.
    bit pend[N];
    int pa[N], pb[N];
    int ptr;
    bit model_idle;
    bit release_pend;
    int mode;      // 0 none, 1 random arrivals, 2 all ports always requesting
    int rr_mode;   // 0 always ready, 1 random, 2 held low
    int stall_exp;
    int ops_exp;
    bit holding;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*W +: W]    = W'(pa[i]);
            req_b[i*W +: W]    = W'(pb[i]);
        end
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 2) != 0);
            default: rsp_ready = 1'b0;
        endcase
    endtask

    task automatic issue(input int p, input int a, input int b);
        pend[p] = 1'b1;
        pa[p]   = a;
        pb[p]   = b;
        drive_inputs();
    endtask

    task automatic refill();
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                if (mode == 2 || (mode == 1 && $urandom_range(0, 9) < 3)) begin
                    pend[i] = 1'b1;
                    pa[i]   = int'($urandom_range(0, 15)) - 8;
                    pb[i]   = int'($urandom_range(0, 15)) - 8;
                end
            end else if (mode == 1 && $urandom_range(0, 19) == 0) begin
                pend[i] = 1'b0;  // requester withdraws before being granted
            end
        end
    endtask

    // Predict this cycle's grant from the pending set and the round-robin pointer.
    task automatic negedge_eval();
        int g;
        int expv;
        bit any;
        if (rst) begin
            stall_exp = 0;
            return;
        end
        chk("busy", int'(busy), int'(!model_idle));
        g   = -1;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (pend[k]) any = 1'b1;
        end
        if (model_idle) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
            end
        end
        expv = (g >= 0) ? (1 << g) : 0;
        chk("req_ready", int'(req_ready), expv);
        if (any && expv == 0) stall_exp++;
        if (g >= 0) begin
            sbq.push_back('{id: g, z: (pa[g] * pb[g]) & 255, acc: cyc});
            ptr        = (g + 1) % N;
            pend[g]    = 1'b0;
            model_idle = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        negedge_eval();
        @(posedge clk);
        #1;
        if (release_pend) begin
            model_idle   = 1'b1;
            release_pend = 1'b0;
        end
        refill();
        drive_inputs();
    endtask

    function automatic bit drained();
        bit d;
        d = model_idle && (sbq.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (pend[i]) d = 1'b0;
        end
        return d;
    endfunction

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!drained() && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (!drained()) begin
            errors++;
            $display("FAIL drain_timeout: pending work after %0d cycles, required none", limit);
        end
    endtask

    // Response monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
            ops_exp = 0;
        end else if (rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rsp: got id %0d z %0d, required no response", rsp_id, rsp_z);
            end else begin
                chk("rsp_id", int'(rsp_id), sbq[0].id);
                chk("rsp_z", int'(rsp_z), sbq[0].z);
                chk("rsp_zf", int'(rsp_zf), int'(sbq[0].z == 0));
                if (!holding) chk("latency", cyc - sbq[0].acc, C + 1);
                holding = 1'b1;
                if (rsp_ready) begin
                    void'(sbq.pop_front());
                    holding      = 1'b0;
                    release_pend = 1'b1;
                    ops_exp++;
                end
            end
        end else if (holding) begin
            checks++;
            errors++;
            $display("FAIL rsp_valid_dropped: got 0 required 1 (cycle %0d)", cyc);
            holding = 1'b0;
        end
    end

    int cnt;

    initial begin
        mode = 0; rr_mode = 0; ptr = 0; model_idle = 1'b1; release_pend = 1'b0;
        stall_exp = 0; ops_exp = 0; holding = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = 0; pb[i] = 0; end

        // Reset with every input high.
        rst = 1'b1; req_valid = '1; req_a = '1; req_b = '1; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_z", int'(rsp_z), 0);
        chk("rst_rsp_zf", int'(rsp_zf), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_exp = 0;
        issue(0, 3, 5);
        wait_idle(20);

        // Signed corners on different ports.
        issue(1, -8, -8); wait_idle(20);
        issue(2, -8, 7);  wait_idle(20);
        issue(3, -1, 1);  wait_idle(20);
        issue(0, 0, -5);  wait_idle(20);
        issue(2, 7, 7);   wait_idle(20);

        // Response back-pressure with another requester waiting.
        rr_mode = 2;
        issue(1, 5, -3);
        issue(3, -4, 6);
        repeat (8) step();
        rr_mode = 0;
        wait_idle(30);

        // All ports requesting continuously.
        mode = 2;
        repeat (40) step();
        mode = 0;
        wait_idle(60);

        // Reset while a request is in CALC: no response, pointer back to 0.
        issue(0, 2, 2); wait_idle(20);       // moves pointer off 0
        issue(2, 3, -2);
        cnt = 0;
        while (model_idle && cnt < 10) begin step(); cnt++; end
        chk("mid_rst_accepted", int'(model_idle), 0);
        pend[1] = 1'b1; pa[1] = 6; pb[1] = -1;
        pend[3] = 1'b1; pa[3] = -7; pb[3] = 3;
        rst = 1'b1;
        drive_inputs();
        step();
        rst = 1'b0;
        sbq.delete();
        ptr = 0; model_idle = 1'b1; release_pend = 1'b0;
        wait_idle(30);

        // Randomized traffic with random back-pressure.
        mode = 1; rr_mode = 1;
        repeat (600) step();
        mode = 0; rr_mode = 0;
        wait_idle(200);

`ifdef MUL_SHARE_ARB_STATS_EN
        chk("stat_ops", int'(stat_ops), ops_exp);
        chk("stat_stall", int'(stat_stall), stall_exp);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one signed two's-complement multiplier datapath between NREQ requesters.
- Each requester presents operands with a valid/ready handshake. The block grants one requester, latches its operands, and holds them stable for CALC_CYCLES cycles while the combinational product settles.
- It then registers the product and presents it with the winner's ID on a single response channel.
- It sits between the operand-producing units and the shared multiplier, so that only one multiplier instance is needed.

Parameters:
- INPUTSIZE, 4, operand width in bits; product width is 2*INPUTSIZE.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of the requester ID; must satisfy 2**IDW >= NREQ.
- CALC_CYCLES, 2, cycles operands are held before the product is sampled (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*INPUTSIZE  packed signed operand A; requester i occupies bits [i*INPUTSIZE +: INPUTSIZE].
- req_b  in  NREQ*INPUTSIZE  packed signed operand B; same packing as req_a.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_z  out  2*INPUTSIZE  signed product.
- rsp_zf  out  1  high when rsp_z == 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_zf=0, busy=0, cycle counter=0.
- State IDLE:
  - req_ready is combinational: a one-hot bit for the first valid requester found searching from rr_ptr upward with wrap-around.
  - When any req_valid is high, the handshake completes that cycle.
  - Latch op_a, op_b and gnt_id; set rr_ptr = (gnt_id+1) mod NREQ; go to CALC with counter=CALC_CYCLES-1.
  - Non-granted requesters stay stalled and must hold valid and operands.
- State CALC:
  - req_ready=0. Multiplier inputs are driven from the latched op_a/op_b only.
  - Counter decrements each cycle. When the counter is 0, register the product into rsp_z, set rsp_zf, set rsp_valid=1 and rsp_id=gnt_id, and go to RESP.
  - Accept-to-rsp_valid latency is CALC_CYCLES+1 cycles.
- State RESP:
  - rsp_* outputs are held stable until rsp_valid && rsp_ready.
  - On that cycle, clear rsp_valid and return to IDLE. A new grant is possible on the next cycle; there is no back-to-back overlap.
- Arithmetic:
  - rsp_z is the exact signed product of op_a and op_b.
  - The most-negative operand is handled exactly: for INPUTSIZE=4, -8*-8 = 64 (0x40) and -8*7 = -56 (0xC8).
- rr_ptr updates only on an accepted grant. A requester dropping valid before acceptance is legal and is simply not granted.
- Reset mid-operation: an in-flight request is discarded, no response is issued, and rr_ptr returns to 0.
- Simultaneous requests: exactly one grant per transaction. rr_ptr guarantees each continuously requesting port is served within NREQ transactions.
- rsp_ready high while rsp_valid=0 has no effect.

Optional Feature:
- Macro: MUL_SHARE_ARB_STATS_EN.
- When defined, two extra output ports are added:
  - stat_ops (16 bits): increments on each completed response handshake and saturates at 0xFFFF.
  - stat_stall (16 bits): increments each cycle in which some req_valid bit is high but no req_ready bit is high, and saturates at 0xFFFF.
  - Both reset to 0.
- When not defined, neither port nor counter exists and the block behaviour is otherwise identical.

Test Plan:
- Reset with all inputs high for 2 cycles -> all outputs 0; after rst drops with req_valid=0001, a=3, b=5 -> req_ready=0001 that cycle; rsp_valid rises 3 cycles later (CALC_CYCLES=2) with rsp_z=0x0F, rsp_id=0, rsp_zf=0.
- Signed corners, INPUTSIZE=4: (-8,-8) -> 0x40; (-8,7) -> 0xC8; (-1,1) -> 0xFF; (0,-5) -> rsp_z=0x00, rsp_zf=1.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; rsp_id matches that order and each port gets one grant per 4 transactions.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_z stable, req_ready=0 throughout; accept on cycle 6 -> IDLE the next cycle.
- rst asserted during CALC -> no rsp_valid is ever produced for that request; rr_ptr=0, so with requests 0010 and 1000 pending, port 1 is granted first.
- MUL_SHARE_ARB_STATS_EN defined: three completed ops with one stalled requester waiting 8 cycles -> stat_ops=3, stat_stall=8.
